// File: rtl/tetris_pkg.sv
// Shared playfield geometry and the line-clearer state type.
package tetris_pkg;

   localparam int ROWS = 30;
   localparam int COLS = 20;

   localparam logic [COLS-1:0] FULL_ROW = {COLS{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      READ,
      EVAL,
      FILL,
      DONE
   } clr_state_t;

endpackage

// File: rtl/board_line_clearer.sv
// Single-pass line clearer: scans the board bottom-up, drops full rows,
// packs surviving rows toward the bottom and zero-fills the rows left on top.
module board_line_clearer
   import tetris_pkg::*;
#(
   parameter int ROWS = tetris_pkg::ROWS,
   parameter int COLS = tetris_pkg::COLS
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [4:0]      rows_cleared,
   output logic [4:0]      rd_addr,
   input  logic [COLS-1:0] rd_data,
   output logic            wr_en,
   output logic [4:0]      wr_addr,
   output logic [COLS-1:0] wr_data
);

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   clr_state_t state_reg, state_next;
   logic [4:0] r_reg, r_next;
   logic [4:0] w_reg, w_next;
   logic [4:0] cnt_reg, cnt_next;
   logic       row_full;

   assign row_full     = &rd_data;
   assign rows_cleared = cnt_reg;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg <= IDLE;
         r_reg     <= LAST_ROW;
         w_reg     <= LAST_ROW;
         cnt_reg   <= 5'd0;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         w_reg     <= w_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      r_next     = r_reg;
      w_next     = w_reg;
      cnt_next   = cnt_reg;
      busy       = 1'b1;
      done       = 1'b0;
      rd_addr    = 5'd0;
      wr_en      = 1'b0;
      wr_addr    = 5'd0;
      wr_data    = '0;

      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               cnt_next   = 5'd0;
               r_next     = LAST_ROW;
               w_next     = LAST_ROW;
               state_next = READ;
            end
         end

         READ: begin
            rd_addr    = r_reg;
            state_next = EVAL;
         end

         EVAL: begin
            if (row_full) begin
               cnt_next = cnt_reg + 5'd1;
            end else begin
               // A survivor already sitting at its destination needs no write.
               if (w_reg != r_reg) begin
                  wr_en   = 1'b1;
                  wr_addr = w_reg;
                  wr_data = rd_data;
               end
               if (w_reg != 5'd0) begin
                  w_next = w_reg - 5'd1;
               end
            end
            if (r_reg == 5'd0) begin
               state_next = (cnt_next != 5'd0) ? FILL : DONE;
            end else begin
               r_next     = r_reg - 5'd1;
               state_next = READ;
            end
         end

         FILL: begin
            wr_en   = 1'b1;
            wr_addr = w_reg;
            if (w_reg == 5'd0) begin
               state_next = DONE;
            end else begin
               w_next = w_reg - 5'd1;
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_board_line_clearer.sv
// Randomized and directed bench for board_line_clearer against a queue-based
// model of row removal and compaction, with an in-bench synchronous board RAM.
module tb_board_line_clearer;
   import tetris_pkg::*;

   localparam int NR = 30;
   localparam int NC = 20;
   localparam logic [NC-1:0] ALL_ONES = {NC{1'b1}};

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, wr_en;
   logic [4:0]    rows_cleared, rd_addr, wr_addr;
   logic [NC-1:0] rd_data, wr_data;

   always #5 clk = ~clk;

   board_line_clearer #(.ROWS(NR), .COLS(NC)) dut (
      .Clk          (clk),
      .Reset_n      (reset_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .rows_cleared (rows_cleared),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data)
   );

   logic [NC-1:0] board     [NR];
   logic [NC-1:0] img       [NR];
   logic [NC-1:0] exp_board [NR];
   logic          ld_req = 1'b0;
   int            wr_cnt = 0;
   int            exp_n, exp_wr;
   int            tests_run = 0;
   int            tests_failed = 0;

   // Board RAM: registered read, write port driven by the DUT, bulk load from the bench.
   always @(posedge clk) begin
      if (ld_req) begin
         for (int i = 0; i < NR; i++) board[i] <= img[i];
         wr_cnt <= 0;
      end else if (wr_en) begin
         if (int'(wr_addr) < NR) board[wr_addr] <= wr_data;
         wr_cnt <= wr_cnt + 1;
      end
      rd_data <= board[rd_addr];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: survivors in bottom-up order land on ROWS-1, ROWS-2, ...; the rest is zero.
   task automatic load_and_model();
      int q[$];
      exp_n  = 0;
      exp_wr = 0;
      for (int i = NR - 1; i >= 0; i--) begin
         if (img[i] == ALL_ONES) exp_n++;
         else q.push_back(i);
      end
      for (int i = 0; i < NR; i++) exp_board[i] = '0;
      foreach (q[k]) begin
         exp_board[NR - 1 - k] = img[q[k]];
         if ((NR - 1 - k) != q[k]) exp_wr++;
      end
      exp_wr += exp_n;
      @(negedge clk);
      ld_req = 1'b1;
      @(negedge clk);
      ld_req = 1'b0;
   endtask

   task automatic run_pass(input string name, input bit poke);
      int cyc, done_cyc, done_cnt, exp_done;
      load_and_model();
      exp_done = 61 + exp_n;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc      = 1;
      done_cyc = -1;
      done_cnt = 0;
      while (cyc <= exp_done + 4 && cyc < 200) begin
         start = poke && (cyc == 10);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_val({name, ".done_cycle"}, done_cyc, exp_done);
      check_val({name, ".done_count"}, done_cnt, 1);
      check_val({name, ".rows_cleared"}, {27'd0, rows_cleared}, exp_n);
      check_val({name, ".writes"}, wr_cnt, exp_wr);
      check_val({name, ".busy_after"}, {31'd0, busy}, 0);
      for (int i = 0; i < NR; i++)
         check_val($sformatf("%s.row%0d", name, i), {12'd0, board[i]}, {12'd0, exp_board[i]});
      $display("[TB] pass %s: cleared=%0d expected=%0d done_cycle=%0d writes=%0d",
               name, rows_cleared, exp_n, done_cyc, wr_cnt);
   endtask

   task automatic random_board(input int full_pct);
      for (int i = 0; i < NR; i++) begin
         if ($urandom_range(99) < full_pct) img[i] = ALL_ONES;
         else img[i] = NC'($urandom) & ~NC'(1 << $urandom_range(NC - 1));
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check_val({name, ".busy"},    {31'd0, busy},  0);
      check_val({name, ".done"},    {31'd0, done},  0);
      check_val({name, ".wr_en"},   {31'd0, wr_en}, 0);
      check_val({name, ".cleared"}, {27'd0, rows_cleared}, 0);
      check_val({name, ".rd_addr"}, {27'd0, rd_addr}, 0);
      check_val({name, ".wr_addr"}, {27'd0, wr_addr}, 0);
      check_val({name, ".wr_data"}, {12'd0, wr_data}, 0);
   endtask

   initial begin
      for (int i = 0; i < NR; i++) img[i] = '0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset_n = 1'b1;

      // Empty board.
      for (int i = 0; i < NR; i++) img[i] = '0;
      run_pass("empty", 1'b0);

      // Only the bottom row full.
      img[NR - 1] = ALL_ONES;
      run_pass("bottom_full", 1'b0);

      // Four full rows under a partial row.
      for (int i = 0; i < NR; i++) img[i] = '0;
      for (int i = 26; i < NR; i++) img[i] = ALL_ONES;
      img[25] = 20'h00F0F;
      run_pass("four_full", 1'b0);

      // Even rows full, odd rows tagged with their index.
      for (int i = 0; i < NR; i++) img[i] = (i % 2 == 0) ? ALL_ONES : NC'(i * 37 + 1);
      run_pass("alternating", 1'b0);

      // Every row full.
      for (int i = 0; i < NR; i++) img[i] = ALL_ONES;
      run_pass("all_full", 1'b0);

      // Start re-asserted mid-pass.
      random_board(30);
      run_pass("restart_ignored", 1'b1);

      for (int t = 0; t < 6; t++) begin
         random_board(15 + 15 * (t % 3));
         run_pass($sformatf("random%0d", t), 1'b0);
      end

      // Reset mid-pass: outputs must drop without a clock edge.
      random_board(20);
      img[NR - 1] = ALL_ONES;
      load_and_model();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      check_val("mid_reset.busy_before", {31'd0, busy}, 1);
      #2 reset_n = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("mid_reset.stays_idle", {31'd0, busy}, 0);
      $display("[TB] pass mid_reset: busy=%0d wr_en=%0d", busy, wr_en);

      random_board(25);
      run_pass("after_reset", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
